// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
//   reg_addr_t : register index (64 architectural registers)
//   uint32_t   : data word
//   wb_req_t   : one buffered writeback {byte enables, dest register, data}
//   WB_PORTS   : number of regfile write ports driven per cycle
package regfile_wb_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 6;
    localparam int unsigned WB_PORTS   = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [31:0]           uint32_t;

    typedef struct packed {
        logic [3:0] we;
        reg_addr_t  waddr;
        uint32_t    wdata;
    } wb_req_t;

    // A request writing r0 or with no byte lanes enabled has no architectural effect.
    function automatic logic wb_is_real(input wb_req_t req);
        return (req.waddr != '0) && (req.we != '0);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick2.sv
// Round-robin two-grant picker.
//   req_i     : per-source request mask (real, buffered writebacks only)
//   waddr_i   : per-source dest register, source i at [REG_ADDR_W*i +: REG_ADDR_W]
//   rr_ptr_i  : source index where the scan starts (wraps around)
//   gnt1_o    : one-hot grant for write port 1
//   gnt2_o    : one-hot grant for write port 2 (never the same waddr as port 1)
//   any_gnt_o : at least one grant issued
//   last_o    : index of the last source granted in scan order
// Purely combinational.
module regfile_wb_arbiter_rr_pick2
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0]            req_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] waddr_i,
    input  logic [PTR_W-1:0]              rr_ptr_i,
    output logic [NUM_SRC-1:0]            gnt1_o,
    output logic [NUM_SRC-1:0]            gnt2_o,
    output logic                          any_gnt_o,
    output logic [PTR_W-1:0]              last_o
);

    reg_addr_t        addr_arr [NUM_SRC];
    int unsigned      idx;
    logic [PTR_W-1:0] sel;
    logic             found1;
    logic             found2;
    reg_addr_t        addr1;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            addr_arr[i] = waddr_i[i*REG_ADDR_W +: REG_ADDR_W];
        end
    end

    always_comb begin
        gnt1_o    = '0;
        gnt2_o    = '0;
        any_gnt_o = 1'b0;
        last_o    = '0;
        found1    = 1'b0;
        found2    = 1'b0;
        addr1     = '0;
        idx       = 0;
        sel       = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = 32'(rr_ptr_i) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            sel = PTR_W'(idx);
            if (req_i[sel]) begin
                if (!found1) begin
                    found1      = 1'b1;
                    gnt1_o[sel] = 1'b1;
                    addr1       = addr_arr[sel];
                    last_o      = sel;
                end else if (!found2 && (addr_arr[sel] != addr1)) begin
                    // Same-register entries are skipped, later ones still compete.
                    found2      = 1'b1;
                    gnt2_o[sel] = 1'b1;
                    last_o      = sel;
                end
            end
        end
        any_gnt_o = found1;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the dual-write-port register file.
// Buffers one result per functional unit and retires up to two real writes per cycle
// through registered write ports, arbitrated round-robin.
//   clk, resetn                : clock (rising edge), async active-low reset
//   flush                      : drop all buffered results this edge
//   src_valid / src_ready      : per-source handshake (src_ready is combinational)
//   src_waddr/src_we/src_wdata : per-source dest reg (6b), byte enables (4b), data (32b)
//   inst1_* / inst2_*          : registered write ports 1 and 2
//   wb_idle                    : no buffered result and no write in flight
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ADDR_W  = REG_ADDR_W
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*ADDR_W-1:0] src_waddr,
    input  logic [NUM_SRC*4-1:0]      src_we,
    input  logic [NUM_SRC*32-1:0]     src_wdata,
    output logic [3:0]                inst1_we,
    output logic [ADDR_W-1:0]         inst1_waddr,
    output logic [31:0]               inst1_wdata,
    output logic [3:0]                inst2_we,
    output logic [ADDR_W-1:0]         inst2_waddr,
    output logic [31:0]               inst2_wdata,
    output logic                      wb_idle
);

    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    wb_req_t                       slot_q [NUM_SRC];
    wb_req_t                       slot_d [NUM_SRC];
    logic [NUM_SRC-1:0]            full_q;
    logic [NUM_SRC-1:0]            full_d;
    logic [PTR_W-1:0]              rr_ptr_q;
    logic [PTR_W-1:0]              rr_ptr_d;
    wb_req_t                       out_q [WB_PORTS];
    wb_req_t                       out_d [WB_PORTS];

    logic [NUM_SRC-1:0]            is_real;
    logic [NUM_SRC-1:0]            null_ret;
    logic [NUM_SRC-1:0]            retire;
    logic [NUM_SRC-1:0]            load;
    logic [NUM_SRC*REG_ADDR_W-1:0] slot_addr_flat;
    logic [NUM_SRC-1:0]            gnt1;
    logic [NUM_SRC-1:0]            gnt2;
    logic                          any_gnt;
    logic [PTR_W-1:0]              last_idx;

    always_comb begin
        is_real        = '0;
        null_ret       = '0;
        slot_addr_flat = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            is_real[i]  = full_q[i] && wb_is_real(slot_q[i]);
            // Null entries leave without using a port.
            null_ret[i] = full_q[i] && !wb_is_real(slot_q[i]);
            slot_addr_flat[i*REG_ADDR_W +: REG_ADDR_W] = slot_q[i].waddr;
        end
    end

    regfile_wb_arbiter_rr_pick2 #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_rr_pick2 (
        .req_i     (is_real),
        .waddr_i   (slot_addr_flat),
        .rr_ptr_i  (rr_ptr_q),
        .gnt1_o    (gnt1),
        .gnt2_o    (gnt2),
        .any_gnt_o (any_gnt),
        .last_o    (last_idx)
    );

    // A slot leaving this edge can be refilled on the same edge.
    assign retire    = gnt1 | gnt2 | null_ret;
    assign src_ready = {NUM_SRC{~flush}} & (~full_q | retire);
    assign load      = src_valid & src_ready;

    always_comb begin
        full_d = full_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            slot_d[i] = slot_q[i];
            if (flush) begin
                full_d[i] = 1'b0;
            end else if (load[i]) begin
                full_d[i]       = 1'b1;
                slot_d[i].we    = src_we[i*4 +: 4];
                slot_d[i].waddr = reg_addr_t'(src_waddr[i*ADDR_W +: ADDR_W]);
                slot_d[i].wdata = src_wdata[i*32 +: 32];
            end else if (retire[i]) begin
                full_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < WB_PORTS; p++) begin
            out_d[p] = '0;
        end
        rr_ptr_d = rr_ptr_q;
        if (!flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (gnt1[i]) begin
                    out_d[0] = slot_q[i];
                end
                if (gnt2[i]) begin
                    out_d[1] = slot_q[i];
                end
            end
            if (any_gnt) begin
                rr_ptr_d = (last_idx == PTR_W'(NUM_SRC - 1)) ? '0 : last_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full_q   <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                slot_q[i] <= '0;
            end
            for (int p = 0; p < WB_PORTS; p++) begin
                out_q[p] <= '0;
            end
        end else begin
            full_q   <= full_d;
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                slot_q[i] <= slot_d[i];
            end
            for (int p = 0; p < WB_PORTS; p++) begin
                out_q[p] <= out_d[p];
            end
        end
    end

    assign inst1_we    = out_q[0].we;
    assign inst1_waddr = ADDR_W'(out_q[0].waddr);
    assign inst1_wdata = out_q[0].wdata;
    assign inst2_we    = out_q[1].we;
    assign inst2_waddr = ADDR_W'(out_q[1].waddr);
    assign inst2_wdata = out_q[1].wdata;

    assign wb_idle = (full_q == '0) && (out_q[0].we == '0) && (out_q[1].we == '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a cycle table plus hand-written corner
// sequences; expected port contents are queued when stimulus is driven and compared
// when the registered outputs update.
module tb_regfile_wb_arbiter;

    localparam int NSRC = 4;
    localparam int NVEC = 14;

    typedef struct packed {
        logic [3:0]  we1;
        logic [5:0]  a1;
        logic [31:0] d1;
        logic [3:0]  we2;
        logic [5:0]  a2;
        logic [31:0] d2;
        logic        idle;
    } exp_t;

    typedef struct packed {
        logic                  do_reset;
        logic                  flush;
        logic [3:0]            valid;
        logic [3:0][5:0]       a;
        logic [3:0][3:0]       w;
        logic [3:0][31:0]      d;
        logic [3:0]            exp_ready;
        exp_t                  exp;
    } vec_t;

    logic                 clk;
    logic                 resetn;
    logic                 flush;
    logic [NSRC-1:0]      src_valid;
    logic [NSRC-1:0]      src_ready;
    logic [NSRC*6-1:0]    src_waddr;
    logic [NSRC*4-1:0]    src_we;
    logic [NSRC*32-1:0]   src_wdata;
    logic [3:0]           inst1_we;
    logic [5:0]           inst1_waddr;
    logic [31:0]          inst1_wdata;
    logic [3:0]           inst2_we;
    logic [5:0]           inst2_waddr;
    logic [31:0]          inst2_wdata;
    logic                 wb_idle;

    vec_t vecs [NVEC];
    exp_t sb [$];
    int   checks;
    int   failures;

    regfile_wb_arbiter #(
        .NUM_SRC (NSRC),
        .ADDR_W  (6)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_waddr   (src_waddr),
        .src_we      (src_we),
        .src_wdata   (src_wdata),
        .inst1_we    (inst1_we),
        .inst1_waddr (inst1_waddr),
        .inst1_wdata (inst1_wdata),
        .inst2_we    (inst2_we),
        .inst2_waddr (inst2_waddr),
        .inst2_wdata (inst2_wdata),
        .wb_idle     (wb_idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t mk_exp(input logic [3:0] we1, input logic [5:0] a1,
                                    input logic [31:0] d1, input logic [3:0] we2,
                                    input logic [5:0] a2, input logic [31:0] d2,
                                    input logic idle);
        exp_t e;
        e.we1 = we1; e.a1 = a1; e.d1 = d1;
        e.we2 = we2; e.a2 = a2; e.d2 = d2;
        e.idle = idle;
        return e;
    endfunction

    task automatic vsrc(input int r, input int s, input logic [5:0] a, input logic [3:0] w,
                        input logic [31:0] d);
        vecs[r].valid[s] = 1'b1;
        vecs[r].a[s]     = a;
        vecs[r].w[s]     = w;
        vecs[r].d[s]     = d;
    endtask

    task automatic clr_in();
        flush     = 1'b0;
        src_valid = '0;
        src_waddr = '0;
        src_we    = '0;
        src_wdata = '0;
    endtask

    task automatic set_src(input int s, input logic [5:0] a, input logic [3:0] w,
                           input logic [31:0] d);
        src_valid[s]          = 1'b1;
        src_waddr[s*6 +: 6]   = a;
        src_we[s*4 +: 4]      = w;
        src_wdata[s*32 +: 32] = d;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clr_in();
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string name, input logic [3:0] exp_rdy);
        #1;
        checks++;
        if (src_ready !== exp_rdy) begin
            failures++;
            $display("FAIL %s ready: got %b want %b", name, src_ready, exp_rdy);
        end
    endtask

    task automatic step_chk(input string name);
        exp_t e;
        exp_t act;
        @(posedge clk);
        #1;
        act = {inst1_we, inst1_waddr, inst1_wdata, inst2_we, inst2_waddr, inst2_wdata,
               wb_idle};
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s out: no expected entry queued", name);
        end else begin
            e = sb.pop_front();
            if (act !== e) begin
                failures++;
                $display("FAIL %s out: got p1=%h/%0d/%h p2=%h/%0d/%h idle=%b want p1=%h/%0d/%h p2=%h/%0d/%h idle=%b",
                         name, act.we1, act.a1, act.d1, act.we2, act.a2, act.d2, act.idle,
                         e.we1, e.a1, e.d1, e.we2, e.a2, e.d2, e.idle);
            end
        end
        checks++;
        if (inst1_we != '0 && inst2_we != '0 && inst1_waddr == inst2_waddr) begin
            failures++;
            $display("FAIL %s dup: both ports write r%0d got conflict want distinct",
                     name, inst1_waddr);
        end
    endtask

    task automatic push(input logic [3:0] we1, input logic [5:0] a1, input logic [31:0] d1,
                        input logic [3:0] we2, input logic [5:0] a2, input logic [31:0] d2,
                        input logic idle);
        sb.push_back(mk_exp(we1, a1, d1, we2, a2, d2, idle));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        clr_in();

        for (int r = 0; r < NVEC; r++) begin
            vecs[r]           = '0;
            vecs[r].exp_ready = 4'hF;
            vecs[r].exp.idle  = 1'b1;
        end
        // Reset state, no traffic.
        // Two sources land on both ports one edge after acceptance.
        vsrc(1, 0, 6'd5, 4'hF, 32'hDEAD_BEEF);
        vsrc(1, 2, 6'd7, 4'h3, 32'h0000_1234);
        vecs[1].exp.idle = 1'b0;
        vecs[2].exp = mk_exp(4'hF, 6'd5, 32'hDEAD_BEEF, 4'h3, 6'd7, 32'h0000_1234, 1'b0);
        // Three sources from rr_ptr = 0: 0,1 then 2; slot 2 stalls one cycle.
        vecs[4].do_reset = 1'b1;
        vsrc(4, 0, 6'd1, 4'hF, 32'h1111_1111);
        vsrc(4, 1, 6'd2, 4'hF, 32'h2222_2222);
        vsrc(4, 2, 6'd3, 4'hF, 32'h3333_3333);
        vecs[4].exp.idle  = 1'b0;
        vecs[5].exp_ready = 4'b1011;
        vecs[5].exp = mk_exp(4'hF, 6'd1, 32'h1111_1111, 4'hF, 6'd2, 32'h2222_2222, 1'b0);
        vecs[6].exp = mk_exp(4'hF, 6'd3, 32'h3333_3333, 4'h0, 6'd0, 32'h0, 1'b0);
        // rr_ptr is now 3: source 3 wins port 1 over source 0.
        vsrc(7, 0, 6'd12, 4'hC, 32'hAAAA_0000);
        vsrc(7, 3, 6'd13, 4'h3, 32'hBBBB_0000);
        vecs[7].exp.idle = 1'b0;
        vecs[8].exp = mk_exp(4'h3, 6'd13, 32'hBBBB_0000, 4'hC, 6'd12, 32'hAAAA_0000, 1'b0);
        // Back-to-back beats from one source: retire and reload on the same edge.
        vsrc(9, 0, 6'd1, 4'h1, 32'h0000_0001);
        vecs[9].exp.idle = 1'b0;
        vsrc(10, 0, 6'd2, 4'h2, 32'h0000_0002);
        vecs[10].exp = mk_exp(4'h1, 6'd1, 32'h1, 4'h0, 6'd0, 32'h0, 1'b0);
        vsrc(11, 0, 6'd3, 4'h4, 32'h0000_0003);
        vecs[11].exp = mk_exp(4'h2, 6'd2, 32'h2, 4'h0, 6'd0, 32'h0, 1'b0);
        vecs[12].exp = mk_exp(4'h4, 6'd3, 32'h3, 4'h0, 6'd0, 32'h0, 1'b0);

        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].do_reset) begin
                do_reset();
            end
            flush     = vecs[i].flush;
            src_valid = vecs[i].valid;
            src_waddr = vecs[i].a;
            src_we    = vecs[i].w;
            src_wdata = vecs[i].d;
            sb.push_back(vecs[i].exp);
            chk_ready($sformatf("vec%0d", i), vecs[i].exp_ready);
            step_chk($sformatf("vec%0d", i));
        end

        // Same destination from sources 1 and 3: consecutive cycles, source 1 first.
        do_reset();
        set_src(1, 6'd9, 4'hF, 32'h0000_009A);
        set_src(3, 6'd9, 4'hF, 32'h0000_009B);
        push(4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 1'b0);
        step_chk("same_load");
        clr_in();
        chk_ready("same_c1", 4'b0111);
        push(4'hF, 6'd9, 32'h9A, 4'h0, 6'd0, 32'h0, 1'b0);
        step_chk("same_c1");
        push(4'hF, 6'd9, 32'h9B, 4'h0, 6'd0, 32'h0, 1'b0);
        step_chk("same_c2");
        push(4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 1'b1);
        step_chk("same_c3");

        // Conflicting entry skipped while a later distinct one takes port 2.
        do_reset();
        set_src(0, 6'd9, 4'hF, 32'h0000_00D0);
        set_src(1, 6'd9, 4'hF, 32'h0000_00D1);
        set_src(2, 6'd11, 4'hF, 32'h0000_00D2);
        push(4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 1'b0);
        step_chk("skip_load");
        clr_in();
        push(4'hF, 6'd9, 32'hD0, 4'hF, 6'd11, 32'hD2, 1'b0);
        step_chk("skip_c1");
        push(4'hF, 6'd9, 32'hD1, 4'h0, 6'd0, 32'h0, 1'b0);
        step_chk("skip_c2");
        push(4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 1'b1);
        step_chk("skip_c3");

        // Null entries (r0 target, zero byte enables) retire without a write.
        do_reset();
        set_src(0, 6'd0, 4'hF, 32'h0000_5555);
        set_src(2, 6'd8, 4'h1, 32'h0000_0088);
        set_src(3, 6'd4, 4'h0, 32'h0000_0044);
        push(4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 1'b0);
        step_chk("null_load");
        clr_in();
        chk_ready("null_c1", 4'hF);
        push(4'h1, 6'd8, 32'h88, 4'h0, 6'd0, 32'h0, 1'b0);
        step_chk("null_c1");
        push(4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 1'b1);
        step_chk("null_c2");
        set_src(1, 6'd0, 4'hF, 32'h0000_0077);
        push(4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 1'b0);
        step_chk("nullonly_load");
        clr_in();
        push(4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 1'b1);
        step_chk("nullonly_c1");

        // Flush with four full slots; a valid in the flush cycle is refused.
        do_reset();
        for (int s = 0; s < NSRC; s++) begin
            set_src(s, 6'(20 + s), 4'hF, 32'h600 + 32'(s));
        end
        push(4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 1'b0);
        step_chk("flush_load");
        clr_in();
        flush = 1'b1;
        set_src(0, 6'd30, 4'hF, 32'h0000_CAFE);
        chk_ready("flush_ready", 4'h0);
        push(4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 1'b1);
        step_chk("flush_edge");
        clr_in();
        push(4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 1'b1);
        step_chk("flush_after");

        // Reset mid-operation: the buffered result never reaches a port.
        do_reset();
        set_src(0, 6'd25, 4'hF, 32'h0000_0025);
        push(4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 1'b0);
        step_chk("rst_load");
        clr_in();
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (!(wb_idle === 1'b1 && inst1_we === 4'h0 && inst2_we === 4'h0)) begin
            failures++;
            $display("FAIL rst_async: got idle=%b we1=%h we2=%h want idle=1 we1=0 we2=0",
                     wb_idle, inst1_we, inst2_we);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (!(wb_idle === 1'b1 && inst1_we === 4'h0 && inst2_we === 4'h0)) begin
            failures++;
            $display("FAIL rst_after: got idle=%b we1=%h we2=%h want idle=1 we1=0 we2=0",
                     wb_idle, inst1_we, inst2_we);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
